fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch and sequencing stage of the 8-bit processor, directly upstream of the control unit.
- Owns the program counter (PC) and the instruction register (IR).
- Fetches one 8-bit instruction per pass through a ready-handshaked instruction memory, then splits it into opcode[7:5] and operand[4:0] and presents them to the control unit.
- Consumes the control unit's J/JC outputs plus an ALU condition flag to choose the next PC.

Parameters:
- ADDR_W, 5, PC/instruction-address width. Must be >= 5. Jump targets are the operand zero-extended to ADDR_W.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- mem_req  out  1  instruction read request
- mem_addr  out  ADDR_W  read address; equals pc
- mem_rdata  in  8  instruction word; valid when mem_ready=1
- mem_ready  in  1  memory data valid for current request
- opcode  out  3  IR[7:5], to control unit OPCode
- operand  out  5  IR[4:0]; immediate / memory address / jump target
- instr_valid  out  1  decoded instruction is executing (EXECUTE state)
- j  in  1  unconditional jump, from control unit J
- jc  in  1  conditional jump, from control unit JC
- cond  in  1  branch condition flag from ALU/flag register
- exec_done  in  1  datapath has finished the current instruction
- pc  out  ADDR_W  current program counter

Behaviour:
- Clock is clk. Reset is rst: synchronous, active-high. It takes priority over every other input, including mid-handshake.
- Reset values:
  - state=FETCH, pc=RESET_PC, IR=8'h00 (so opcode=0, operand=0)
  - mem_req=0, instr_valid=0
  - mem_req rises in the first cycle after rst deasserts.
- States: FETCH, DECODE, EXECUTE. All outputs are registered or decoded only from state/IR; no combinational input-to-output paths.
- FETCH:
  - mem_req=1, mem_addr=pc, held stable until the handshake completes.
  - On an edge where mem_req=1 and mem_ready=1: IR<=mem_rdata, next state DECODE.
  - While mem_ready=0: stay in FETCH. Wait is unbounded.
- DECODE:
  - Exactly one cycle. mem_req=0, instr_valid=0.
  - opcode/operand already reflect the new IR, giving the control unit a settling cycle.
  - Next state EXECUTE.
- EXECUTE:
  - instr_valid=1; IR held.
  - Stay until exec_done=1. On that edge, update pc:
    - j=1: pc<=zext(operand).
    - else jc=1 and cond=1: pc<=zext(operand).
    - else: pc<=pc+1, wrapping modulo 2^ADDR_W (e.g. 31 -> 0 at ADDR_W=5).
  - Next state FETCH. instr_valid drops in the same edge.
- j and jc both high: j wins. Target is identical, so only the priority matters.
- j, jc and cond are sampled only on the exec_done edge in EXECUTE; they are ignored elsewhere.
- exec_done outside EXECUTE is ignored.
- mem_ready while mem_req=0 is ignored; no IR load.
- exec_done already high on entry to EXECUTE: instr_valid is high for exactly one cycle.
- Minimum instruction period is 3 cycles (mem_ready and exec_done both immediate).
- opcode/operand change only on a FETCH-completion edge or on reset. They are stable through DECODE and EXECUTE.
- Reset mid-operation, in any state, including a pending mem_req: next cycle is the reset state and the in-flight fetch is abandoned.

Decomposition:
- Shared header cpu_defs.vh (`include`-d by fetch_unit, the control unit and benches) holds:
  - opcode field localparams (OP_MSB=7, OP_LSB=5, OPND_W=5)
  - the 3-bit opcode encodings
  - state encodings S_FETCH=2'd0, S_DECODE=2'd1, S_EXECUTE=2'd2
- One natural sub-module, program_counter. It holds the ADDR_W register with reset-to-RESET_PC, a load port (target, load_en) and an increment port (inc_en). Load has priority over increment.
- The state machine and IR stay in fetch_unit.

Test Plan:
- Reset/straight-line: rst=1 for 2 cycles, then memory returns 8'h21@0, 8'h42@1, 8'h63@2 with mem_ready immediate and exec_done immediate:
  - pc sequence 0,1,2,3
  - opcode 1,2,3 with operand 1,2,3
  - new fetch every 3 cycles
  - instr_valid a 1-cycle pulse each time
- Memory wait: mem_ready held low 4 cycles at pc=0 → mem_req=1 and mem_addr=0 held all 4 cycles, IR unchanged. Data 8'hA5 is captured on the ready edge → opcode=5, operand=5.
- Jumps: at pc=3, assert j with operand=5'd17 → next mem_addr=17. At pc=17, jc=1 with cond=0 → pc=18. At pc=18, jc=1 with cond=1 and operand=5'd2 → pc=2. j=jc=1 with operand=9 → pc=9.
- Wrap and stall: pc=31 with no jump → next pc=0. exec_done held low 5 cycles → instr_valid high for 5 cycles and pc unchanged until exec_done.
- Reset mid-fetch: rst asserted while mem_req=1 and pc=12 → next cycle pc=0, IR=0, mem_req=0, instr_valid=0. Fetch restarts at address 0 in the following cycle.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage: instruction field layout, sequencer
// state encoding and the branch-decision helper.
package fetch_unit_pkg;

   localparam int OP_MSB = 7;
   localparam int OP_LSB = 5;
   localparam int OPND_W = 5;

   typedef enum logic [1:0] {
      S_FETCH   = 2'd0,
      S_DECODE  = 2'd1,
      S_EXECUTE = 2'd2
   } state_t;

   // j wins over jc, but both jump to the same operand target.
   function automatic logic take_branch(input logic j, input logic jc, input logic cond);
      return j | (jc & cond);
   endfunction

endpackage

// File: rtl/program_counter.sv
// Program counter register: reset to RESET_PC, absolute load, wrapping increment.
module program_counter #(
   parameter int          ADDR_W   = 5,
   parameter int unsigned RESET_PC = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_en,
   input  logic [ADDR_W-1:0] target,
   input  logic              inc_en,
   output logic [ADDR_W-1:0] pc
);

   always_ff @(posedge clk) begin
      if (rst) begin
         pc <= ADDR_W'(RESET_PC);
      end else if (load_en) begin
         pc <= target;
      end else if (inc_en) begin
         pc <= pc + ADDR_W'(1);
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch/sequence stage: FETCH -> DECODE -> EXECUTE loop that owns
// the IR and drives the program counter.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int          ADDR_W   = 5,
   parameter int unsigned RESET_PC = 0
) (
   input  logic              clk,
   input  logic              rst,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [7:0]        mem_rdata,
   input  logic              mem_ready,
   output logic [2:0]        opcode,
   output logic [4:0]        operand,
   output logic              instr_valid,
   input  logic              j,
   input  logic              jc,
   input  logic              cond,
   input  logic              exec_done,
   output logic [ADDR_W-1:0] pc,
   output state_t            dbg_state
);

   state_t            state_q, state_d;
   logic [7:0]        ir_q;
   logic              mem_req_q;
   logic              ir_load;
   logic              pc_load;
   logic              pc_inc;
   logic [ADDR_W-1:0] pc_target;

   // Handshake: mem_req acts as valid and mem_ready as ready; a read completes
   // only on an edge where both are 1, and mem_addr stays fixed until then.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_FETCH;
         ir_q      <= 8'h00;
         mem_req_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         mem_req_q <= (state_d == S_FETCH);
         if (ir_load) begin
            ir_q <= mem_rdata;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      ir_load = 1'b0;
      pc_load = 1'b0;
      pc_inc  = 1'b0;
      case (state_q)
         S_FETCH: begin
            if (mem_req_q && mem_ready) begin
               ir_load = 1'b1;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            state_d = S_EXECUTE;
         end
         S_EXECUTE: begin
            if (exec_done) begin
               state_d = S_FETCH;
               if (take_branch(j, jc, cond)) begin
                  pc_load = 1'b1;
               end else begin
                  pc_inc = 1'b1;
               end
            end
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase
   end

   assign pc_target = ADDR_W'(ir_q[OPND_W-1:0]);

   program_counter #(
      .ADDR_W   (ADDR_W),
      .RESET_PC (RESET_PC)
   ) u_pc (
      .clk     (clk),
      .rst     (rst),
      .load_en (pc_load),
      .target  (pc_target),
      .inc_en  (pc_inc),
      .pc      (pc)
   );

   assign mem_req     = mem_req_q;
   assign mem_addr    = pc;
   assign opcode      = ir_q[OP_MSB:OP_LSB];
   assign operand     = ir_q[OPND_W-1:0];
   assign instr_valid = (state_q == S_EXECUTE);
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: transaction-level model pushes per-cycle expected
// outputs into a queue that one compare process checks on every falling edge.
module tb_fetch_unit;
   import fetch_unit_pkg::*;

   localparam int AW = 5;
   localparam int W  = 21;

   logic          clk       = 1'b0;
   logic          rst       = 1'b1;
   logic          mem_ready = 1'b0;
   logic [7:0]    mem_rdata = 8'h00;
   logic          exec_done = 1'b0;
   logic          j         = 1'b0;
   logic          jc        = 1'b0;
   logic          cond      = 1'b0;
   logic          mem_req;
   logic [AW-1:0] mem_addr;
   logic [2:0]    opcode;
   logic [4:0]    operand;
   logic          instr_valid;
   logic [AW-1:0] pc;
   state_t        dbg_state;

   fetch_unit #(.ADDR_W(AW), .RESET_PC(0)) dut (
      .clk         (clk),
      .rst         (rst),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_rdata   (mem_rdata),
      .mem_ready   (mem_ready),
      .opcode      (opcode),
      .operand     (operand),
      .instr_valid (instr_valid),
      .j           (j),
      .jc          (jc),
      .cond        (cond),
      .exec_done   (exec_done),
      .pc          (pc),
      .dbg_state   (dbg_state)
   );

   always #5 clk = ~clk;

   // Entry layout: {check, mem_req, mem_addr[4:0], ir[7:0], instr_valid, pc[4:0]}
   logic [W-1:0] exp_q[$];
   int           checks = 0;
   int           passes = 0;
   logic [4:0]   m_pc   = 5'd0;
   logic [7:0]   m_ir   = 8'h00;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic logic [7:0] rd();
      return 8'($urandom);
   endfunction

   initial begin : compare
      logic [W-1:0] e;
      forever begin
         @(negedge clk);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            if (e[20]) begin
               check("mem_req",     int'(mem_req),     int'(e[19]));
               check("mem_addr",    int'(mem_addr),    int'(e[18:14]));
               check("opcode",      int'(opcode),      int'(e[13:11]));
               check("operand",     int'(operand),     int'(e[10:6]));
               check("instr_valid", int'(instr_valid), int'(e[5]));
               check("pc",          int'(pc),          int'(e[4:0]));
            end
         end
      end
   end

   // One clock of stimulus; expected outputs reflect the model before this edge.
   task automatic cycle(input logic r, input logic rdy, input logic [7:0] data,
                        input logic ed, input logic jj, input logic jjc, input logic cc,
                        input logic chk, input logic req_e, input logic iv_e);
      @(posedge clk);
      #1;
      rst       = r;
      mem_ready = rdy;
      mem_rdata = data;
      exec_done = ed;
      j         = jj;
      jc        = jjc;
      cond      = cc;
      exp_q.push_back({chk, req_e, m_pc, m_ir, iv_e, m_pc});
   endtask

   task automatic reset_seq(input int n, input logic chk_first, input logic req_e, input logic iv_e);
      cycle(1'b1, rb(), rd(), rb(), rb(), rb(), rb(), chk_first, req_e, iv_e);
      m_pc = 5'd0;
      m_ir = 8'h00;
      for (int i = 1; i < n; i++) cycle(1'b1, rb(), rd(), rb(), rb(), rb(), rb(), 1'b1, 1'b0, 1'b0);
      // first cycle out of reset: request still low, so a stray ready is ignored
      cycle(1'b0, rb(), rd(), rb(), rb(), rb(), rb(), 1'b1, 1'b0, 1'b0);
   endtask

   task automatic fetch_wait(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, rd(), rb(), rb(), rb(), rb(), 1'b1, 1'b1, 1'b0);
   endtask

   task automatic fetch_take(input logic [7:0] data);
      cycle(1'b0, 1'b1, data, rb(), rb(), rb(), rb(), 1'b1, 1'b1, 1'b0);
      m_ir = data;
   endtask

   task automatic decode_cyc();
      cycle(1'b0, rb(), rd(), rb(), rb(), rb(), rb(), 1'b1, 1'b0, 1'b0);
   endtask

   task automatic exec_wait(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, rb(), rd(), 1'b0, rb(), rb(), rb(), 1'b1, 1'b0, 1'b1);
   endtask

   task automatic exec_finish(input logic jj, input logic jjc, input logic cc);
      cycle(1'b0, rb(), rd(), 1'b1, jj, jjc, cc, 1'b1, 1'b0, 1'b1);
      if (jj || (jjc && cc)) m_pc = m_ir[4:0];
      else m_pc = 5'((int'(m_pc) + 1) % 32);
   endtask

   task automatic instr(input int rw, input logic [7:0] data, input int dw,
                        input logic jj, input logic jjc, input logic cc);
      fetch_wait(rw);
      fetch_take(data);
      decode_cyc();
      exec_wait(dw);
      exec_finish(jj, jjc, cc);
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1);
   end

   initial begin : main
      reset_seq(2, 1'b0, 1'b0, 1'b0);

      instr(0, 8'h21, 0, 1'b0, 1'b0, 1'b0);
      instr(0, 8'h42, 0, 1'b0, 1'b0, 1'b0);
      instr(0, 8'h63, 0, 1'b0, 1'b0, 1'b0);
      check("model_pc_straight", int'(m_pc), 3);
      check("model_opcode_straight", int'(m_ir[7:5]), 3);

      reset_seq(2, 1'b1, 1'b1, 1'b0);
      instr(4, 8'hA5, 0, 1'b0, 1'b0, 1'b0);
      check("model_opcode_wait", int'(m_ir[7:5]), 5);
      check("model_operand_wait", int'(m_ir[4:0]), 5);

      instr(0, 8'h02, 0, 1'b0, 1'b0, 1'b0);
      instr(0, 8'h03, 0, 1'b0, 1'b0, 1'b0);
      check("model_pc_before_jump", int'(m_pc), 3);
      instr(0, {3'd6, 5'd17}, 0, 1'b1, 1'b0, 1'b0);
      check("model_pc_j", int'(m_pc), 17);
      instr(1, {3'd7, 5'd4}, 0, 1'b0, 1'b1, 1'b0);
      check("model_pc_jc_not_taken", int'(m_pc), 18);
      instr(0, {3'd1, 5'd2}, 0, 1'b0, 1'b1, 1'b1);
      check("model_pc_jc_taken", int'(m_pc), 2);
      instr(0, {3'd2, 5'd9}, 0, 1'b1, 1'b1, 1'b0);
      check("model_pc_j_and_jc", int'(m_pc), 9);
      instr(0, {3'd0, 5'd31}, 0, 1'b1, 1'b0, 1'b0);
      instr(0, 8'h80, 0, 1'b0, 1'b0, 1'b1);
      check("model_pc_wrap", int'(m_pc), 0);
      instr(0, 8'h44, 5, 1'b0, 1'b0, 1'b0);
      check("model_pc_stall", int'(m_pc), 1);

      instr(0, {3'd3, 5'd12}, 0, 1'b1, 1'b0, 1'b0);
      fetch_wait(2);
      reset_seq(2, 1'b1, 1'b1, 1'b0);
      check("model_pc_mid_fetch_reset", int'(m_pc), 0);
      instr(0, 8'h21, 0, 1'b0, 1'b0, 1'b0);

      for (int k = 0; k < 200; k++) begin
         case ($urandom_range(0, 19))
            0: begin
               fetch_wait($urandom_range(0, 3));
               reset_seq($urandom_range(1, 3), 1'b1, 1'b1, 1'b0);
            end
            1: begin
               fetch_wait($urandom_range(0, 2));
               fetch_take(rd());
               decode_cyc();
               exec_wait($urandom_range(0, 3));
               reset_seq($urandom_range(1, 3), 1'b1, 1'b0, 1'b1);
            end
            default: begin
               instr($urandom_range(0, 3), rd(), $urandom_range(0, 3), rb(), rb(), rb());
            end
         endcase
      end

      @(negedge clk);
      #1;
      for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clk);
      #1;
      check("queue_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
